censor_stream_packer: RTL and testbench

CENSOR_STREAM_PACKER -- requirements
Module: censor_stream_packer

---
 rtl/censor_pkg.sv | 22 ++
 rtl/censor_word_fifo.sv | 63 ++++++
 rtl/censor_stream_packer.sv | 157 +++++++++++++++
 tb/tb_censor_stream_packer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/censor_pkg.sv
// censor_pkg: shared constants, FIFO entry type and keep-mask helper for the
// censor stream packer.
package censor_pkg;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_MASK  = 8'h2A;
    localparam int         WORD_W     = 32;
    localparam int         KEEP_W     = 4;

    // One output beat as stored in the word FIFO.
    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } word_entry_t;

    // Byte-enable mask for a partial word holding 'lanes' bytes (lanes 1..3).
    function automatic logic [KEEP_W-1:0] keep_mask(input logic [1:0] lanes);
        return (4'b0001 << lanes) - 4'b0001;
    endfunction

endpackage

// File: rtl/censor_word_fifo.sv
// censor_word_fifo: synchronous FIFO of word_entry_t with full/empty flags.
// A push while full is accepted only when a pop frees a slot on the same edge.
module censor_word_fifo
    import censor_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  word_entry_t push_entry,
    input  logic        pop,
    output word_entry_t pop_entry,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;
    word_entry_t mem_q [DEPTH];

    // Pointer arithmetic and flags; the extra pointer bit separates full from empty.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clock) begin
        // NOTE: the array is not reset; emptiness comes from the pointers and reads are gated below.
        if (reset && do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
    end

    // Head entry, forced to zero while empty so stale storage never reaches the port.
    always_comb begin
        pop_entry = '0;
        if (!empty) pop_entry = mem_q[rd_ptr_q[AW-1:0]];
    end

endmodule

// File: rtl/censor_stream_packer.sv
// censor_stream_packer: packs censored bytes little-endian into 32-bit words,
// frames them on data_valid falling edges and streams them out over AXI-Stream.
// Optional feature macro: CENSOR_PACK_STATS_EN adds stat_censored / stat_frames.
module censor_stream_packer
    import censor_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  char_in,
    input  logic        data_valid,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        overflow
`ifdef CENSOR_PACK_STATS_EN
    ,
    output logic [15:0] stat_censored,
    output logic [15:0] stat_frames
`endif
);

    logic [1:0]        lane_q, lane_d;
    logic [WORD_W-1:0] part_q, part_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic              dv_q, dv_d;
    logic              ovf_q, ovf_d;

    logic              accept, eof;
    logic              push, pop, fifo_full, fifo_empty;
    word_entry_t       push_entry, head_entry;

    // Byte packing, end-of-frame detection and FIFO push selection.
    always_comb begin
        lane_d     = lane_q;
        part_d     = part_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        dv_d       = dv_q;
        ovf_d      = ovf_q;
        push       = 1'b0;
        push_entry = '0;

        accept = enable && data_valid;
        eof    = enable && dv_q && !data_valid;
        pop    = m_axis_tvalid && m_axis_tready;

        if (enable) dv_d = data_valid;

        if (accept) begin
            // First byte of a new word releases the previous complete word.
            if (lane_q == 2'd0 && hold_vld_q) begin
                push       = 1'b1;
                push_entry = '{data: hold_q, keep: 4'hF, last: 1'b0};
                hold_vld_d = 1'b0;
            end
            if (lane_q == 2'd3) begin
                hold_d     = {char_in, part_q[23:0]};
                hold_vld_d = 1'b1;
                part_d     = '0;
                lane_d     = 2'd0;
            end else begin
                part_d[{lane_q, 3'b000} +: 8] = char_in;
                lane_d = lane_q + 2'd1;
            end
        end else if (eof) begin
            if (lane_q == 2'd0) begin
                if (hold_vld_q) begin
                    push       = 1'b1;
                    push_entry = '{data: hold_q, keep: 4'hF, last: 1'b1};
                end
            end else begin
                push       = 1'b1;
                push_entry = '{data: part_q, keep: keep_mask(lane_q), last: 1'b1};
            end
            lane_d     = 2'd0;
            part_d     = '0;
            hold_d     = '0;
            hold_vld_d = 1'b0;
        end

        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    // Input-side state registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lane_q     <= '0;
            part_q     <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            dv_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            part_q     <= part_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            dv_q       <= dv_d;
            ovf_q      <= ovf_d;
        end
    end

    censor_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .pop_entry  (head_entry),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = head_entry.data;
    assign m_axis_tkeep  = head_entry.keep;
    assign m_axis_tlast  = head_entry.last;
    assign overflow      = ovf_q;

`ifdef CENSOR_PACK_STATS_EN
    logic [15:0] censored_q, censored_d;
    logic [15:0] frames_q, frames_d;

    // Saturating counters of accepted mask characters and end-of-frame events.
    always_comb begin
        censored_d = censored_q;
        frames_d   = frames_q;
        if (accept && char_in == CHAR_MASK && censored_q != 16'hFFFF)
            censored_d = censored_q + 16'd1;
        if (eof && frames_q != 16'hFFFF)
            frames_d = frames_q + 16'd1;
    end

    // Statistics registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            censored_q <= '0;
            frames_q   <= '0;
        end else begin
            censored_q <= censored_d;
            frames_q   <= frames_d;
        end
    end

    assign stat_censored = censored_q;
    assign stat_frames   = frames_q;
`endif

endmodule

// File: tb/tb_censor_stream_packer.sv
// tb_censor_stream_packer: table vectors, directed corner sequences and random
// stimulus against a byte-queue reference model of the packer.
module tb_censor_stream_packer;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset, enable, data_valid, m_axis_tready;
    logic [7:0]  char_in;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast, m_axis_tvalid, overflow;
`ifdef CENSOR_PACK_STATS_EN
    logic [15:0] stat_censored, stat_frames;
`endif

    always #5 clock = ~clock;

    censor_stream_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .char_in       (char_in),
        .data_valid    (data_valid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .overflow      (overflow)
`ifdef CENSOR_PACK_STATS_EN
        ,
        .stat_censored (stat_censored),
        .stat_frames   (stat_frames)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] cur[$];      // bytes of the frame not yet pushed
    logic       m_dv_prev = 1'b0;
    logic       m_ovf = 1'b0;
    int         m_cens = 0;
    int         m_frames = 0;

    function automatic word_t make_word(input logic last);
        word_t w;
        w.data = '0;
        for (int i = 0; i < cur.size(); i++) w.data[8*i +: 8] = cur[i];
        w.keep = 4'((1 << cur.size()) - 1);
        w.last = last;
        return w;
    endfunction

    task automatic model_edge(input logic en, input logic dv, input logic [7:0] ch,
                              input logic rdy, input logic rst);
        word_t w;
        logic  emit, do_pop;
        emit = 1'b0;
        w    = '0;
        if (!rst) begin
            exp_q.delete();
            cur.delete();
            m_dv_prev = 1'b0;
            m_ovf     = 1'b0;
            m_cens    = 0;
            m_frames  = 0;
        end else begin
            do_pop = (exp_q.size() > 0) && rdy;
            if (en && dv) begin
                if (cur.size() == 4) begin
                    w = make_word(1'b0);
                    emit = 1'b1;
                    cur.delete();
                end
                cur.push_back(ch);
                if (ch == 8'h2A && m_cens < 65535) m_cens++;
            end else if (en && m_dv_prev && !dv) begin
                if (cur.size() > 0) begin
                    w = make_word(1'b1);
                    emit = 1'b1;
                end
                cur.delete();
                if (m_frames < 65535) m_frames++;
            end
            if (en) m_dv_prev = dv;
            if (do_pop) void'(exp_q.pop_front());
            if (emit) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(w);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare_outputs();
        check("tvalid", m_axis_tvalid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            check("tdata", m_axis_tdata, exp_q[0].data);
            check("tkeep", m_axis_tkeep, exp_q[0].keep);
            check("tlast", m_axis_tlast, exp_q[0].last);
        end
        check("overflow", overflow, m_ovf);
`ifdef CENSOR_PACK_STATS_EN
        check("stat_censored", stat_censored, m_cens);
        check("stat_frames", stat_frames, m_frames);
`endif
    endtask

    // Drive one cycle of inputs, advance model and DUT, compare after the edge.
    task automatic cycle(input logic en, input logic dv, input logic [7:0] ch,
                         input logic rdy, input logic rst);
        enable        = en;
        data_valid    = dv;
        char_in       = ch;
        m_axis_tready = rdy;
        reset         = rst;
        model_edge(en, dv, ch, rdy, rst);
        @(posedge clock);
        #1;
        compare_outputs();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        en;
        logic        dv;
        logic [7:0]  ch;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        el;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [31:0] w_exp;

        // "ab**" frame, then 01..06 frame with output held off for a few cycles.
        vecs[0]  = '{1, 1, 8'h61, 1, 0, 32'h0, 4'h0, 0};
        vecs[1]  = '{1, 1, 8'h62, 1, 0, 32'h0, 4'h0, 0};
        vecs[2]  = '{1, 1, 8'h2A, 1, 0, 32'h0, 4'h0, 0};
        vecs[3]  = '{1, 1, 8'h2A, 1, 0, 32'h0, 4'h0, 0};
        vecs[4]  = '{1, 0, 8'h00, 1, 1, 32'h2A2A6261, 4'hF, 1};
        vecs[5]  = '{1, 0, 8'h00, 1, 0, 32'h0, 4'h0, 0};
        vecs[6]  = '{1, 1, 8'h01, 1, 0, 32'h0, 4'h0, 0};
        vecs[7]  = '{1, 1, 8'h02, 1, 0, 32'h0, 4'h0, 0};
        vecs[8]  = '{1, 1, 8'h03, 1, 0, 32'h0, 4'h0, 0};
        vecs[9]  = '{1, 1, 8'h04, 0, 0, 32'h0, 4'h0, 0};
        vecs[10] = '{1, 1, 8'h05, 0, 1, 32'h04030201, 4'hF, 0};
        vecs[11] = '{1, 1, 8'h06, 0, 1, 32'h04030201, 4'hF, 0};
        vecs[12] = '{1, 0, 8'h00, 0, 1, 32'h04030201, 4'hF, 0};
        vecs[13] = '{1, 0, 8'h00, 1, 1, 32'h00000605, 4'h3, 1};
        vecs[14] = '{1, 0, 8'h00, 1, 0, 32'h0, 4'h0, 0};

        // Reset state.
        cycle(0, 0, 8'h00, 0, 0);
        cycle(0, 0, 8'h00, 0, 0);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tdata", m_axis_tdata, 32'h0);
        check("rst_tkeep", m_axis_tkeep, 4'h0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_overflow", overflow, 1'b0);

        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].en, vecs[i].dv, vecs[i].ch, vecs[i].rdy, 1);
            check($sformatf("vec%0d_tvalid", i), m_axis_tvalid, vecs[i].ev);
            if (vecs[i].ev) begin
                check($sformatf("vec%0d_tdata", i), m_axis_tdata, vecs[i].ed);
                check($sformatf("vec%0d_tkeep", i), m_axis_tkeep, vecs[i].ek);
                check($sformatf("vec%0d_tlast", i), m_axis_tlast, vecs[i].el);
            end
        end

        // 40-byte frame against a stalled output: 8 words kept, overflow set.
        for (int i = 1; i <= 40; i++) cycle(1, 1, 8'(i), 0, 1);
        cycle(1, 0, 8'h00, 0, 1);
        check("stall_overflow", overflow, 1'b1);
        for (int w = 0; w < 8; w++) begin
            w_exp = '0;
            for (int b = 0; b < 4; b++) w_exp[8*b +: 8] = 8'(4*w + b + 1);
            check($sformatf("stall_w%0d_valid", w), m_axis_tvalid, 1'b1);
            check($sformatf("stall_w%0d_data", w), m_axis_tdata, w_exp);
            check($sformatf("stall_w%0d_keep", w), m_axis_tkeep, 4'hF);
            check($sformatf("stall_w%0d_last", w), m_axis_tlast, 1'b0);
            cycle(1, 0, 8'h00, 1, 1);
        end
        check("stall_drained", m_axis_tvalid, 1'b0);
        check("stall_overflow_sticky", overflow, 1'b1);

        // Freeze mid-frame with data_valid low: no frame end, same lane afterwards.
        cycle(1, 1, 8'h11, 1, 1);
        cycle(1, 1, 8'h22, 1, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 8'h00, 1, 1);
            check($sformatf("freeze%0d_tvalid", i), m_axis_tvalid, 1'b0);
        end
        cycle(1, 1, 8'h33, 0, 1);
        cycle(1, 1, 8'h44, 0, 1);
        cycle(1, 0, 8'h00, 0, 1);
        check("freeze_tdata", m_axis_tdata, 32'h44332211);
        check("freeze_tkeep", m_axis_tkeep, 4'hF);
        check("freeze_tlast", m_axis_tlast, 1'b1);
        cycle(1, 0, 8'h00, 1, 1);

        // Reset with three words queued and a partial word pending.
        for (int i = 1; i <= 12; i++) cycle(1, 1, 8'(8'h80 + i), 0, 1);
        cycle(1, 0, 8'h00, 0, 1);
        cycle(1, 1, 8'h55, 0, 1);
        cycle(1, 1, 8'h56, 0, 1);
        check("prereset_tvalid", m_axis_tvalid, 1'b1);
        cycle(1, 1, 8'h57, 0, 0);
        check("midrst_tvalid", m_axis_tvalid, 1'b0);
        check("midrst_overflow", overflow, 1'b0);
        check("midrst_tdata", m_axis_tdata, 32'h0);
        check("midrst_tlast", m_axis_tlast, 1'b0);
`ifdef CENSOR_PACK_STATS_EN
        check("midrst_censored", stat_censored, 16'h0);
        check("midrst_frames", stat_frames, 16'h0);
`endif
        cycle(1, 1, 8'h77, 1, 1);
        cycle(1, 0, 8'h00, 0, 1);
        check("postrst_tdata", m_axis_tdata, 32'h00000077);
        check("postrst_tkeep", m_axis_tkeep, 4'h1);
        check("postrst_tlast", m_axis_tlast, 1'b1);
        cycle(1, 0, 8'h00, 1, 1);
        check("postrst_empty", m_axis_tvalid, 1'b0);

`ifdef CENSOR_PACK_STATS_EN
        // Two frames holding five mask characters in total.
        cycle(1, 0, 8'h00, 1, 0);
        cycle(1, 1, 8'h2A, 1, 1);
        cycle(1, 1, 8'h41, 1, 1);
        cycle(1, 1, 8'h2A, 1, 1);
        cycle(1, 0, 8'h00, 1, 1);
        cycle(1, 1, 8'h2A, 1, 1);
        cycle(1, 1, 8'h42, 1, 1);
        cycle(1, 1, 8'h2A, 1, 1);
        cycle(1, 1, 8'h2A, 1, 1);
        cycle(1, 0, 8'h00, 1, 1);
        check("stats_censored", stat_censored, 16'd5);
        check("stats_frames", stat_frames, 16'd2);
`endif

        // Randomized traffic: a low-ready phase to provoke drops, then a fast drain phase.
        for (int i = 0; i < 3000; i++) begin
            logic en, dv, rdy, rst;
            logic [7:0] ch;
            en  = ($urandom_range(0, 9) != 0);
            dv  = ($urandom_range(0, 9) < 7);
            rdy = (i < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
            rst = ($urandom_range(0, 399) != 0);
            ch  = ($urandom_range(0, 3) == 0) ? 8'h2A : 8'($urandom);
            cycle(en, dv, ch, rdy, rst);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
